display_scan_hex: RTL

Time-multiplexed driver for a 4-digit common-anode 7-segment display. It consumes the four hex nibbles and the alert flag produced by the alarm control FSM and scans them onto shared segment lines, one digit at a time. Each scan frame uses a coherent snapshot of the inputs. A blanking guard at the start of every digit slot prevents ghosting, and the whole display blinks while alert is active.

---
 rtl/display_scan_hex.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/display_scan_hex.sv
// Multiplexed driver for a 4-digit common-anode 7-segment display.
// Each frame shows a coherent input snapshot, with a guard blank per slot and an alert blink.
module display_scan_hex #(
    parameter int REFRESH_DIV  = 50000,
    parameter int BLANK_CYCLES = 500,
    parameter int BLINK_FRAMES = 125
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] hexa3,
    input  logic [3:0] hexa2,
    input  logic [3:0] hexa1,
    input  logic [3:0] hexa0,
    input  logic [3:0] punto,
    input  logic       alerta,
    output logic [3:0] an,
    output logic [6:0] seg,
    output logic       dp,
    output logic       frame_tick
);

    localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int BLK_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(REFRESH_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_BLANK = CNT_W'(BLANK_CYCLES);
    localparam logic [BLK_W-1:0] BLK_LAST  = BLK_W'(BLINK_FRAMES - 1);

    typedef enum logic {
        PH_ON  = 1'b0,
        PH_OFF = 1'b1
    } phase_t;

    logic [CNT_W-1:0] r_cnt;
    logic [1:0]       r_idx;
    logic [3:0]       r_snap [4];
    logic [3:0]       r_punto;
    logic [BLK_W-1:0] r_blink_cnt;
    logic [BLK_W-1:0] w_blink_cnt_next;
    phase_t           r_phase;
    phase_t           w_phase_next;
    logic [3:0]       r_an;
    logic [6:0]       r_seg;
    logic             r_dp;

    logic [3:0]       w_hexa [4];
    logic             w_slot_end;
    logic             w_frame_start;
    logic             w_blank;
    logic [3:0]       w_an_next;
    logic [6:0]       w_seg_next;
    logic             w_dp_next;

    function automatic logic [6:0] hex_to_seg(input logic [3:0] h);
        logic [6:0] s;
        case (h)
            4'h0: s = 7'h40;
            4'h1: s = 7'h79;
            4'h2: s = 7'h24;
            4'h3: s = 7'h30;
            4'h4: s = 7'h19;
            4'h5: s = 7'h12;
            4'h6: s = 7'h02;
            4'h7: s = 7'h78;
            4'h8: s = 7'h00;
            4'h9: s = 7'h10;
            4'hA: s = 7'h08;
            4'hB: s = 7'h03;
            4'hC: s = 7'h46;
            4'hD: s = 7'h21;
            4'hE: s = 7'h06;
            default: s = 7'h0E;
        endcase
        return s;
    endfunction

    assign w_hexa[0] = hexa0;
    assign w_hexa[1] = hexa1;
    assign w_hexa[2] = hexa2;
    assign w_hexa[3] = hexa3;

    assign w_slot_end    = (r_cnt == CNT_LAST);
    assign w_frame_start = (r_cnt == '0) && (r_idx == 2'd0);
    assign frame_tick    = w_slot_end && (r_idx == 2'd3);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt <= '0;
            r_idx <= 2'd0;
        end else if (w_slot_end) begin
            r_cnt <= '0;
            r_idx <= r_idx + 2'd1;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // Snapshot lands on a blanked output cycle, so a digit never changes mid-slot.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 4; i++) begin
                r_snap[i] <= 4'h0;
            end
            r_punto <= 4'h0;
        end else if (w_frame_start) begin
            for (int i = 0; i < 4; i++) begin
                r_snap[i] <= w_hexa[i];
            end
            r_punto <= punto;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_phase     <= PH_ON;
            r_blink_cnt <= '0;
        end else begin
            r_phase     <= w_phase_next;
            r_blink_cnt <= w_blink_cnt_next;
        end
    end

    // Dropping alerta always restarts the next blink with a full on half-period.
    always_comb begin
        w_phase_next     = r_phase;
        w_blink_cnt_next = r_blink_cnt;
        if (!alerta) begin
            w_phase_next     = PH_ON;
            w_blink_cnt_next = '0;
        end else if (frame_tick) begin
            if (r_blink_cnt == BLK_LAST) begin
                w_blink_cnt_next = '0;
                w_phase_next     = (r_phase == PH_ON) ? PH_OFF : PH_ON;
            end else begin
                w_blink_cnt_next = r_blink_cnt + 1'b1;
            end
        end
    end

    always_comb begin
        w_blank    = (r_cnt < CNT_BLANK) || (r_phase == PH_OFF);
        w_an_next  = 4'b1111;
        w_seg_next = 7'h7F;
        w_dp_next  = 1'b1;
        if (!w_blank) begin
            w_an_next  = ~(4'b0001 << r_idx);
            w_seg_next = hex_to_seg(r_snap[r_idx]);
            w_dp_next  = ~r_punto[r_idx];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_an  <= 4'b1111;
            r_seg <= 7'h7F;
            r_dp  <= 1'b1;
        end else begin
            r_an  <= w_an_next;
            r_seg <= w_seg_next;
            r_dp  <= w_dp_next;
        end
    end

    assign an  = r_an;
    assign seg = r_seg;
    assign dp  = r_dp;

endmodule
